// File: rtl/stage_seq_pkg.sv
// rtl/stage_seq_pkg.sv - shared types and fault codes for the stage sequencer
// Purpose: control-op encoding and 4-bit fault codes used by stage_sequencer.
package stage_seq_pkg;

    typedef enum logic [1:0] {
        CTRL_TRAP    = 2'b00,
        CTRL_EXT_INT = 2'b01,
        CTRL_SW_INT  = 2'b10,
        CTRL_NORMAL  = 2'b11
    } ctrl_op_e;

    localparam logic [3:0] FAULT_INSTR_MISALIGNED = 4'b0000;
    localparam logic [3:0] FAULT_INSTR_ACCESS     = 4'b0001;
    localparam logic [3:0] FAULT_ILLEGAL_INSTR    = 4'b0010;
    localparam logic [3:0] FAULT_LOAD_MISALIGNED  = 4'b0100;
    localparam logic [3:0] FAULT_LOAD_ACCESS      = 4'b0101;
    localparam logic [3:0] FAULT_STORE_MISALIGNED = 4'b0110;
    localparam logic [3:0] FAULT_STORE_ACCESS     = 4'b0111;
    localparam logic [3:0] FAULT_STAGE_TIMEOUT    = 4'b1000;

endpackage

// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - stage handshake bundle between sequencer and datapath
// Purpose: groups the per-stage handshake.
//   stage_done   : datapath -> sequencer, current stage finished
//   stage_skip   : datapath -> sequencer, stages to bypass on next advance
//   stage_active : sequencer -> datapath, one-hot current stage
//   stage_enter  : sequencer -> datapath, first cycle of a stage
interface stage_sequencer_if #(
    parameter int NUM_STAGES = 8
);
    logic                  stage_done;
    logic [NUM_STAGES-1:0] stage_skip;
    logic [NUM_STAGES-1:0] stage_active;
    logic                  stage_enter;

    modport master (
        input  stage_done,
        input  stage_skip,
        output stage_active,
        output stage_enter
    );

    modport slave (
        output stage_done,
        output stage_skip,
        input  stage_active,
        input  stage_enter
    );
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder
// Purpose: returns whether any request is set and the index of the lowest one.
//   req   : request vector
//   valid : any bit of req set
//   idx   : index of the lowest set bit (0 when none)
module irq_prio_enc #(
    parameter int W     = 4,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - one-hot multi-cycle stage sequencer with fault abort
// Purpose: steps a one-hot stage vector on stage_done, skips marked stages,
// aborts to control stage 0 on faults or dwell timeout, and latches a control
// operation on every entry to stage 0.
//   clk, reset_n           : clock, synchronous active-low reset
//   stg (master)           : stage_done/stage_skip in, stage_active/stage_enter out
//   illegal_instr_fault,
//   mem_addr_fault,
//   mem_access_fault,
//   mem_fault_is_store     : fault inputs
//   irq, irq_en, sw_int    : interrupt requests
//   control_op, irq_id     : operation latched on entry to stage 0
//   fault_num, fault_pending : last fault code, fault awaiting stage 0
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 8,
    parameter int FETCH_STAGE = 1,
    parameter int MEM_STAGE   = 5,
    parameter int NUM_IRQ     = 4,
    parameter int TIMEOUT     = 255,
    parameter int IRQ_ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    stage_sequencer_if.master   stg,
    input  logic                illegal_instr_fault,
    input  logic                mem_addr_fault,
    input  logic                mem_access_fault,
    input  logic                mem_fault_is_store,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic [NUM_IRQ-1:0]  irq_en,
    input  logic                sw_int,
    output ctrl_op_e            control_op,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [3:0]          fault_num,
    output logic                fault_pending
);

    localparam int STG_IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int DWELL_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DWELL_W-1:0] DWELL_MAX   = '1;
    localparam logic [DWELL_W-1:0] TIMEOUT_VAL = DWELL_W'(TIMEOUT);

    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  enter_q, enter_d;
    ctrl_op_e              ctrl_q, ctrl_d;
    logic [IRQ_ID_W-1:0]   irq_id_q, irq_id_d;
    logic [3:0]            fault_num_q, fault_num_d;
    logic                  pend_q, pend_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;

    logic                  eligible, in_ctrl, in_fetch, in_mem, timeout_hit;
    logic                  fault_hit, advance;
    logic [3:0]            fault_code;
    logic [NUM_STAGES-1:0] above_mask, cand, next_adv;
    logic                  nxt_valid;
    logic [STG_IDX_W-1:0]  nxt_idx;
    logic                  irq_valid;
    logic [IRQ_ID_W-1:0]   irq_idx;

    // Next-stage search: lowest non-skipped index strictly above the current one.
    // For a one-hot vector, (s << 1) - 1 covers the current bit and everything below;
    // at the top stage the shift overflows to 0 and the mask becomes empty.
    assign above_mask = ~((stage_q << 1) - NUM_STAGES'(1));
    assign cand       = above_mask & ~stg.stage_skip;

    irq_prio_enc #(.W(NUM_STAGES), .IDX_W(STG_IDX_W)) u_next_stage (
        .req   (cand),
        .valid (nxt_valid),
        .idx   (nxt_idx)
    );

    irq_prio_enc #(.W(NUM_IRQ), .IDX_W(IRQ_ID_W)) u_irq_sel (
        .req   (irq & irq_en),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    assign eligible = ~enter_q;
    assign in_ctrl  = stage_q[0];
    assign in_fetch = stage_q[FETCH_STAGE];
    assign in_mem   = stage_q[MEM_STAGE];
    assign timeout_hit = (TIMEOUT != 0) && !in_ctrl && (dwell_q == TIMEOUT_VAL)
                         && !stg.stage_done;
    assign next_adv = nxt_valid ? (NUM_STAGES'(1) << nxt_idx) : NUM_STAGES'(1);

    always_comb begin
        fault_hit  = 1'b0;
        fault_code = FAULT_INSTR_MISALIGNED;
        if (eligible) begin
            if (illegal_instr_fault && !in_ctrl) begin
                fault_hit  = 1'b1;
                fault_code = FAULT_ILLEGAL_INSTR;
            end else if (mem_addr_fault && (in_fetch || in_mem)) begin
                fault_hit  = 1'b1;
                fault_code = in_fetch ? FAULT_INSTR_MISALIGNED :
                             mem_fault_is_store ? FAULT_STORE_MISALIGNED : FAULT_LOAD_MISALIGNED;
            end else if (mem_access_fault && (in_fetch || in_mem)) begin
                fault_hit  = 1'b1;
                fault_code = in_fetch ? FAULT_INSTR_ACCESS :
                             mem_fault_is_store ? FAULT_STORE_ACCESS : FAULT_LOAD_ACCESS;
            end else if (timeout_hit) begin
                fault_hit  = 1'b1;
                fault_code = FAULT_STAGE_TIMEOUT;
            end
        end
    end

    always_comb begin
        advance     = eligible && stg.stage_done && !fault_hit;
        stage_d     = stage_q;
        enter_d     = 1'b0;
        ctrl_d      = ctrl_q;
        irq_id_d    = irq_id_q;
        fault_num_d = fault_num_q;
        pend_d      = pend_q;
        dwell_d     = dwell_q;

        if (fault_hit) begin
            stage_d     = NUM_STAGES'(1);
            enter_d     = 1'b1;
            fault_num_d = fault_code;
            pend_d      = 1'b1;
        end else if (advance) begin
            stage_d = next_adv;
            enter_d = 1'b1;
            if (in_ctrl) begin
                pend_d = 1'b0;
            end
        end

        // Any transition into stage 0 (abort, wrap or stage 0 re-entry) latches an op.
        if (enter_d && stage_d[0]) begin
            if (pend_d) begin
                ctrl_d = CTRL_TRAP;
            end else if (irq_valid) begin
                ctrl_d   = CTRL_EXT_INT;
                irq_id_d = irq_idx;
            end else if (sw_int) begin
                ctrl_d = CTRL_SW_INT;
            end else begin
                ctrl_d = CTRL_NORMAL;
            end
        end

        if (enter_d) begin
            dwell_d = '0;
        end else if (eligible && dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_q     <= NUM_STAGES'(1);
            enter_q     <= 1'b1;
            ctrl_q      <= CTRL_NORMAL;
            irq_id_q    <= '0;
            fault_num_q <= 4'b0000;
            pend_q      <= 1'b0;
            dwell_q     <= '0;
        end else begin
            stage_q     <= stage_d;
            enter_q     <= enter_d;
            ctrl_q      <= ctrl_d;
            irq_id_q    <= irq_id_d;
            fault_num_q <= fault_num_d;
            pend_q      <= pend_d;
            dwell_q     <= dwell_d;
        end
    end

    assign stg.stage_active = stage_q;
    assign stg.stage_enter  = enter_q;
    assign control_op       = ctrl_q;
    assign irq_id           = irq_id_q;
    assign fault_num        = fault_num_q;
    assign fault_pending    = pend_q;

endmodule
